// File: rtl/module_display_7seg_mux.sv
// Two-digit multiplexed 7-segment driver: shows a latched 4-bit code as 00..15,
// alternating units/tens every 2**CNT_WIDTH clocks with dead time between digits.
module module_display_7seg_mux #(
  parameter int CNT_WIDTH   = 16,
  parameter int DEAD_CYCLES = 4,
  parameter int BLANK_ZERO  = 1
) (
  input  logic       clk_pi,
  input  logic       rst_pi,
  input  logic [3:0] codigo_bin_pi,
  input  logic       dato_valido_pi,
  output logic [1:0] anodo_po,
  output logic [6:0] catodo_po,
  output logic       refresco_po
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] DEAD_LIM = CNT_WIDTH'(DEAD_CYCLES);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sel_q, sel_d;
  logic [3:0]           valor_q, valor_d;
  logic [1:0]           anodo_q, anodo_d;
  logic [6:0]           catodo_q, catodo_d;
  logic                 refresco_q, refresco_d;

  logic                 tens;
  logic [3:0]           units;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  endfunction

  always_comb begin
    tens  = (valor_q >= 4'd10);
    units = tens ? (valor_q - 4'd10) : valor_q;

    valor_d = dato_valido_pi ? codigo_bin_pi : valor_q;

    cnt_d      = cnt_q + 1'b1;
    sel_d      = sel_q;
    refresco_d = 1'b0;
    if (cnt_q == CNT_MAX) begin
      sel_d      = ~sel_q;
      refresco_d = sel_q;  // high for the clock after a tens->units switch
    end

    // Outputs follow the current state, so they trail cnt/sel/valor by a clock.
    anodo_d  = 2'b11;
    catodo_d = 7'h7F;
    if (cnt_q >= DEAD_LIM) begin
      if (!sel_q) begin
        anodo_d  = 2'b10;
        catodo_d = seg(units);
      end else if (!((BLANK_ZERO != 0) && !tens)) begin
        anodo_d  = 2'b01;
        catodo_d = seg({3'b000, tens});
      end
    end
  end

  always_ff @(posedge clk_pi) begin
    if (!rst_pi) begin
      cnt_q      <= '0;
      sel_q      <= 1'b0;
      valor_q    <= 4'd0;
      anodo_q    <= 2'b11;
      catodo_q   <= 7'h7F;
      refresco_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      valor_q    <= valor_d;
      anodo_q    <= anodo_d;
      catodo_q   <= catodo_d;
      refresco_q <= refresco_d;
    end
  end

  assign anodo_po    = anodo_q;
  assign catodo_po   = catodo_q;
  assign refresco_po = refresco_q;

endmodule

// File: tb/tb_module_display_7seg_mux.sv
// Bench for module_display_7seg_mux with CNT_WIDTH=4, DEAD_CYCLES=2, BLANK_ZERO=1;
// a cycle model pushes expected pin values each clock, compared one edge later.
module tb_module_display_7seg_mux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] code = 4'd0;
  logic       strobe = 1'b0;
  logic [1:0] anodo;
  logic [6:0] catodo;
  logic       refresco;

  module_display_7seg_mux #(.CNT_WIDTH(4), .DEAD_CYCLES(2), .BLANK_ZERO(1)) dut (
    .clk_pi(clk), .rst_pi(rst_n), .codigo_bin_pi(code), .dato_valido_pi(strobe),
    .anodo_po(anodo), .catodo_po(catodo), .refresco_po(refresco)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] an;
    logic [6:0] cat;
    logic       rf;
  } exp_t;

  exp_t exp_q[$];
  logic [6:0] seg_tb [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  int checks = 0;
  int errors = 0;

  // reference model state
  int   m_cnt = 0;
  logic m_sel = 1'b0;
  int   m_val = 0;

  // observation trackers
  int         cyc = 0;
  logic [1:0] o_an;
  logic [6:0] o_cat;
  logic       o_rf;
  logic       prev_rf = 1'b0;
  logic       mon = 1'b0;
  logic       seen_lit = 1'b0;
  int         dark_run = 0;
  int         last_rf_cyc = -1;
  logic [6:0] last_units;
  logic [6:0] last_tens;
  logic       saw_units;
  logic       saw_tens;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic step();
    exp_t e;
    exp_t g;
    int   tn;
    int   un;
    if (!rst_n) begin
      e = '{an: 2'b11, cat: 7'h7F, rf: 1'b0};
      m_cnt = 0; m_sel = 1'b0; m_val = 0;
    end else begin
      tn = (m_val >= 10) ? 1 : 0;
      un = m_val - 10 * tn;
      e = '{an: 2'b11, cat: 7'h7F, rf: (m_cnt == 15) && m_sel};
      if (m_cnt >= 2) begin
        if (!m_sel) e = '{an: 2'b10, cat: seg_tb[un], rf: e.rf};
        else if (tn != 0) e = '{an: 2'b01, cat: seg_tb[1], rf: e.rf};
      end
      if (strobe) m_val = int'(code);
      if (m_cnt == 15) begin m_cnt = 0; m_sel = ~m_sel; end
      else m_cnt++;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    o_an = anodo; o_cat = catodo; o_rf = refresco;
    g = exp_q.pop_front();
    check("anodo", int'(o_an), int'(g.an));
    check("catodo", int'(o_cat), int'(g.cat));
    check("refresco", int'(o_rf), int'(g.rf));
    checks++;
    assert (o_an !== 2'b00) else begin
      errors++;
      $error("FAIL anodo_both_on: observed %b expected not 00", o_an);
    end
    if (o_an == 2'b10) begin saw_units = 1'b1; last_units = o_cat; end
    if (o_an == 2'b01) begin saw_tens = 1'b1; last_tens = o_cat; end
    if (mon) begin
      if (o_an == 2'b11) dark_run++;
      else begin
        if (seen_lit && dark_run != 0) check("dead_time_len", dark_run, 2);
        dark_run = 0;
        seen_lit = 1'b1;
      end
      if (o_rf) begin
        check("refresco_width", int'(prev_rf), 0);
        if (last_rf_cyc >= 0) check("refresco_period", cyc - last_rf_cyc, 32);
        last_rf_cyc = cyc;
      end
    end
    prev_rf = o_rf;
  endtask

  task automatic clear_track();
    saw_units = 1'b0; saw_tens = 1'b0;
    last_units = 7'h7F; last_tens = 7'h7F;
  endtask

  task automatic load(input logic [3:0] v);
    code = v; strobe = 1'b1;
    step();
    strobe = 1'b0;
    clear_track();
  endtask

  initial begin
    clear_track();
    // 1. reset and release
    rst_n = 1'b0;
    repeat (3) step();
    check("reset_anodo", int'(o_an), 2'b11);
    check("reset_catodo", int'(o_cat), 7'h7F);
    rst_n = 1'b1;
    step(); check("release_dark1", int'(o_an), 2'b11);
    step(); check("release_dark2", int'(o_an), 2'b11);
    step(); check("release_units_an", int'(o_an), 2'b10);
    check("release_units_cat", int'(o_cat), 7'h40);

    // 2/3. sweep all codes, each over one full refresh period
    for (int v = 0; v < 16; v++) begin
      load(4'(v));
      repeat (33) step();
      check("sweep_units_seen", int'(saw_units), 1);
      check("sweep_units_cat", int'(last_units), int'(seg_tb[(v >= 10) ? v - 10 : v]));
      check("sweep_tens_seen", int'(saw_tens), (v >= 10) ? 1 : 0);
      if (v >= 10) check("sweep_tens_cat", int'(last_tens), 7'h79);
    end

    // 4. strobe low, input toggling: value 7 must hold
    load(4'd7);
    for (int i = 0; i < 64; i++) begin
      code = (i % 2 == 0) ? 4'd13 : 4'd2;
      step();
    end
    check("hold_units_cat", int'(last_units), 7'h78);
    check("hold_tens_blank", int'(saw_tens), 0);

    // 5. timing with both digits lit
    load(4'd13);
    mon = 1'b1;
    repeat (100) step();
    mon = 1'b0;
    check("refresco_seen", (last_rf_cyc >= 0) ? 1 : 0, 1);

    // 6. one-clock reset mid tens phase
    for (int i = 0; i < 40 && !(m_sel && m_cnt >= 5); i++) step();
    check("mid_tens_an", int'(o_an), 2'b01);
    rst_n = 1'b0;
    step();
    check("midrst_anodo", int'(o_an), 2'b11);
    check("midrst_catodo", int'(o_cat), 7'h7F);
    rst_n = 1'b1;
    step(); check("resume_dark1", int'(o_an), 2'b11);
    step(); check("resume_dark2", int'(o_an), 2'b11);
    step(); check("resume_units_an", int'(o_an), 2'b10);
    check("resume_units_cat", int'(o_cat), 7'h40);
    clear_track();
    repeat (32) step();
    check("resume_tens_blank", int'(saw_tens), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
